// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register: captures register-file operands, patches them with
// MEM/WB bypass data, flags EX->EX bypass, and inserts load-use bubbles.
module id_ex_operand_stage #(
  parameter int GPR_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [ADDR_WIDTH-1:0] id_rs,
  input  logic [ADDR_WIDTH-1:0] id_rt,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_writes_rd,
  input  logic                  id_is_load,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic [GPR_WIDTH-1:0]  rf_data_rs,
  input  logic [GPR_WIDTH-1:0]  rf_data_rt,
  input  logic                  mem_fwd_en,
  input  logic [ADDR_WIDTH-1:0] mem_fwd_rd,
  input  logic [GPR_WIDTH-1:0]  mem_fwd_data,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [GPR_WIDTH-1:0]  wb_data,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [GPR_WIDTH-1:0]  ex_rs_val,
  output logic [GPR_WIDTH-1:0]  ex_rt_val,
  output logic                  ex_rs_alu_fwd,
  output logic                  ex_rt_alu_fwd,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic                  ex_writes_rd,
  output logic                  ex_is_load,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic [15:0]           stall_cnt
);

  logic                  ex_valid_q, ex_valid_d;
  logic [GPR_WIDTH-1:0]  ex_rs_val_q, ex_rs_val_d;
  logic [GPR_WIDTH-1:0]  ex_rt_val_q, ex_rt_val_d;
  logic                  ex_rs_alu_fwd_q, ex_rs_alu_fwd_d;
  logic                  ex_rt_alu_fwd_q, ex_rt_alu_fwd_d;
  logic [ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_writes_rd_q, ex_writes_rd_d;
  logic                  ex_is_load_q, ex_is_load_d;
  logic [CTRL_WIDTH-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  logic adv;
  logic hazard;
  logic capture;
  logic alu_hit_rs, alu_hit_rt;
  logic [GPR_WIDTH-1:0] rs_res, rt_res;

  assign adv    = ex_ready | ~ex_valid_q;
  assign hazard = ex_valid_q & ex_is_load_q & ex_writes_rd_q &
                  ((id_uses_rs & (id_rs == ex_rd_q)) |
                   (id_uses_rt & (id_rt == ex_rd_q)));
  assign id_ready = adv & ~hazard & ~flush;
  assign capture  = id_ready & id_valid;

  // The ALU result of the bundle now in EX is not available yet; EX picks it
  // up itself, so the captured value on an ALU hit is just the stale rf data.
  assign alu_hit_rs = ex_valid_q & ex_writes_rd_q & ~ex_is_load_q & (id_rs == ex_rd_q);
  assign alu_hit_rt = ex_valid_q & ex_writes_rd_q & ~ex_is_load_q & (id_rt == ex_rd_q);

  always_comb begin
    rs_res = rf_data_rs;
    if (alu_hit_rs)                               rs_res = rf_data_rs;
    else if (mem_fwd_en && (mem_fwd_rd == id_rs)) rs_res = mem_fwd_data;
    else if (wb_en && (wb_rd == id_rs))           rs_res = wb_data;

    rt_res = rf_data_rt;
    if (alu_hit_rt)                               rt_res = rf_data_rt;
    else if (mem_fwd_en && (mem_fwd_rd == id_rt)) rt_res = mem_fwd_data;
    else if (wb_en && (wb_rd == id_rt))           rt_res = wb_data;
  end

  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_rs_val_d     = ex_rs_val_q;
    ex_rt_val_d     = ex_rt_val_q;
    ex_rs_alu_fwd_d = ex_rs_alu_fwd_q;
    ex_rt_alu_fwd_d = ex_rt_alu_fwd_q;
    ex_rd_d         = ex_rd_q;
    ex_writes_rd_d  = ex_writes_rd_q;
    ex_is_load_d    = ex_is_load_q;
    ex_ctrl_d       = ex_ctrl_q;
    stall_cnt_d     = stall_cnt_q;

    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (capture) begin
      ex_valid_d      = 1'b1;
      ex_rs_val_d     = rs_res;
      ex_rt_val_d     = rt_res;
      ex_rs_alu_fwd_d = alu_hit_rs & id_uses_rs;
      ex_rt_alu_fwd_d = alu_hit_rt & id_uses_rt;
      ex_rd_d         = id_rd;
      ex_writes_rd_d  = id_writes_rd;
      ex_is_load_d    = id_is_load;
      ex_ctrl_d       = id_ctrl;
    end else if (adv) begin
      ex_valid_d = 1'b0;
    end

    if (id_valid && hazard && adv && !flush && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_rs_val_q     <= '0;
      ex_rt_val_q     <= '0;
      ex_rs_alu_fwd_q <= 1'b0;
      ex_rt_alu_fwd_q <= 1'b0;
      ex_rd_q         <= '0;
      ex_writes_rd_q  <= 1'b0;
      ex_is_load_q    <= 1'b0;
      ex_ctrl_q       <= '0;
      stall_cnt_q     <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rs_val_q     <= ex_rs_val_d;
      ex_rt_val_q     <= ex_rt_val_d;
      ex_rs_alu_fwd_q <= ex_rs_alu_fwd_d;
      ex_rt_alu_fwd_q <= ex_rt_alu_fwd_d;
      ex_rd_q         <= ex_rd_d;
      ex_writes_rd_q  <= ex_writes_rd_d;
      ex_is_load_q    <= ex_is_load_d;
      ex_ctrl_q       <= ex_ctrl_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_rs_val     = ex_rs_val_q;
  assign ex_rt_val     = ex_rt_val_q;
  assign ex_rs_alu_fwd = ex_rs_alu_fwd_q;
  assign ex_rt_alu_fwd = ex_rt_alu_fwd_q;
  assign ex_rd         = ex_rd_q;
  assign ex_writes_rd  = ex_writes_rd_q;
  assign ex_is_load    = ex_is_load_q;
  assign ex_ctrl       = ex_ctrl_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: expected bundles are queued when an
// instruction is issued and compared when it appears on the EX side.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt, id_writes_rd, id_is_load;
  logic [15:0] id_ctrl;
  logic [31:0] rf_data_rs, rf_data_rt;
  logic        mem_fwd_en;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] ex_rs_val, ex_rt_val;
  logic        ex_rs_alu_fwd, ex_rt_alu_fwd;
  logic [4:0]  ex_rd;
  logic        ex_writes_rd, ex_is_load;
  logic [15:0] ex_ctrl;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rs_f;
    logic        rt_f;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic [15:0] ctrl;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_writes_rd(id_writes_rd), .id_is_load(id_is_load),
    .id_ctrl(id_ctrl),
    .rf_data_rs(rf_data_rs), .rf_data_rt(rf_data_rt),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_rs_alu_fwd(ex_rs_alu_fwd), .ex_rt_alu_fwd(ex_rt_alu_fwd),
    .ex_rd(ex_rd), .ex_writes_rd(ex_writes_rd), .ex_is_load(ex_is_load),
    .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic urs, input logic urt, input logic wr, input logic ld,
                          input logic [15:0] ctrl, input logic [31:0] rfs, input logic [31:0] rft);
    id_valid = 1'b1;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt; id_writes_rd = wr; id_is_load = ld;
    id_ctrl = ctrl; rf_data_rs = rfs; rf_data_rt = rft;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd1);
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".rs_val"}, ex_rs_val, e.rs_val);
    chk({tag, ".rt_val"}, ex_rt_val, e.rt_val);
    chk({tag, ".rs_fwd"}, {31'd0, ex_rs_alu_fwd}, {31'd0, e.rs_f});
    chk({tag, ".rt_fwd"}, {31'd0, ex_rt_alu_fwd}, {31'd0, e.rt_f});
    chk({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
    chk({tag, ".wr_ld"}, {30'd0, ex_writes_rd, ex_is_load}, {30'd0, e.wr, e.ld});
    chk({tag, ".ctrl"}, {16'd0, ex_ctrl}, {16'd0, e.ctrl});
    $display("txn %s rs=%h rt=%h fwd=%b%b rd=%0d ctrl=%h", tag, ex_rs_val, ex_rt_val,
             ex_rs_alu_fwd, ex_rt_alu_fwd, ex_rd, ex_ctrl);
  endtask

  // Called at posedge+1: drive, check acceptance, clock it in, compare output.
  task automatic issue(input string tag,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic urs, input logic urt, input logic wr, input logic ld,
                       input logic [15:0] ctrl, input logic [31:0] rfs, input logic [31:0] rft,
                       input logic [31:0] ers, input logic [31:0] ert,
                       input logic efs, input logic eft);
    exp_t e;
    drive_id(rs, rt, rd, urs, urt, wr, ld, ctrl, rfs, rft);
    e.rs_val = ers; e.rt_val = ert; e.rs_f = efs; e.rt_f = eft;
    e.rd = rd; e.wr = wr; e.ld = ld; e.ctrl = ctrl;
    sb.push_back(e);
    #1;
    chk({tag, ".id_ready"}, {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1;
    id_valid = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_writes_rd = 0; id_is_load = 0; id_ctrl = 0;
    rf_data_rs = 0; rf_data_rt = 0;
    mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0;
    flush = 0; ex_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset.rs_val", ex_rs_val, 32'd0);
    chk("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset.id_ready", {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1;

    // Plain capture
    issue("plain", 5'd3, 5'd4, 5'd1, 1, 1, 0, 0, 16'h0001, 32'h11, 32'h22,
          32'h11, 32'h22, 0, 0);
    // WB bypass
    wb_en = 1; wb_rd = 5'd3; wb_data = 32'hAA;
    issue("wb_fwd", 5'd3, 5'd4, 5'd1, 1, 1, 0, 0, 16'h0002, 32'h11, 32'h22,
          32'hAA, 32'h22, 0, 0);
    // MEM beats WB
    mem_fwd_en = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hBB;
    issue("mem_over_wb", 5'd3, 5'd4, 5'd1, 1, 1, 0, 0, 16'h0003, 32'h11, 32'h22,
          32'hBB, 32'h22, 0, 0);
    mem_fwd_en = 0; wb_en = 0;

    // ADD r5 then SUB using r5
    issue("add_r5", 5'd1, 5'd2, 5'd5, 1, 1, 1, 0, 16'h0010, 32'h1, 32'h2,
          32'h1, 32'h2, 0, 0);
    issue("sub_alu_fwd", 5'd5, 5'd7, 5'd8, 1, 1, 1, 0, 16'h0020, 32'h55, 32'h77,
          32'h55, 32'h77, 1, 0);
    issue("unused_rs", 5'd8, 5'd9, 5'd9, 0, 1, 0, 0, 16'h0030, 32'h66, 32'h99,
          32'h66, 32'h99, 0, 0);

    // Load-use: LW r6 then a consumer of r6
    issue("lw_r6", 5'd10, 5'd11, 5'd6, 1, 1, 1, 1, 16'h0040, 32'hA0, 32'hB0,
          32'hA0, 32'hB0, 0, 0);
    drive_id(5'd12, 5'd6, 5'd13, 1, 1, 1, 0, 16'h0050, 32'hC0, 32'hDEAD);
    #1;
    chk("hazard.id_ready", {31'd0, id_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bubble.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("bubble.stall_cnt", {16'd0, stall_cnt}, 32'd1);
    $display("txn bubble ex_valid=%b stall_cnt=%0d", ex_valid, stall_cnt);
    mem_fwd_en = 1; mem_fwd_rd = 5'd6; mem_fwd_data = 32'h1234;
    issue("load_use_mem", 5'd12, 5'd6, 5'd13, 1, 1, 1, 0, 16'h0050, 32'hC0, 32'hDEAD,
          32'hC0, 32'h1234, 0, 0);
    mem_fwd_en = 0;

    // Back-pressure: bundle must hold for three cycles
    ex_ready = 0;
    drive_id(5'd14, 5'd15, 5'd2, 1, 1, 0, 0, 16'h0060, 32'h5, 32'h6);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold.id_ready", {31'd0, id_ready}, 32'd0);
      @(posedge clk); #1;
      chk("hold.ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("hold.rt_val", ex_rt_val, 32'h1234);
      chk("hold.rd", {27'd0, ex_rd}, 32'd13);
      $display("txn hold%0d ex_valid=%b rt=%h", i, ex_valid, ex_rt_val);
    end
    flush = 1;
    #1;
    chk("flush.id_ready", {31'd0, id_ready}, 32'd0);
    @(posedge clk); #1;
    chk("flush.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush.stall_cnt", {16'd0, stall_cnt}, 32'd1);
    $display("txn flush ex_valid=%b", ex_valid);
    flush = 0; ex_ready = 1;

    // After flush nothing is in EX, so r13 is not ALU-forwarded
    issue("post_flush", 5'd13, 5'd15, 5'd2, 1, 1, 1, 0, 16'h0070, 32'h5, 32'h6,
          32'h5, 32'h6, 0, 0);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst.rs_val", ex_rs_val, 32'd0);
    chk("async_rst.ctrl", {16'd0, ex_ctrl}, 32'd0);
    chk("async_rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("async_rst.flags", {28'd0, ex_writes_rd, ex_rs_alu_fwd, ex_rt_alu_fwd, ex_is_load}, 32'd0);
    $display("txn async_rst ex_valid=%b stall_cnt=%0d", ex_valid, stall_cnt);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("scoreboard.empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the 16-entry GPR register file.
- Captures the asynchronous data_rs/data_rt read values and corrects them with MEM/WB bypass data, since a same-cycle register-file write is not visible to a same-cycle read.
- Detects load-use hazards and inserts bubbles.
- Presents a valid/ready-handshaked operand bundle to the execute stage.

Parameters:
GPR_WIDTH, 32, operand/data width
ADDR_WIDTH, 5, register index width (file holds 16 entries; indices 16-31 are illegal and treated as ordinary for compare)
CTRL_WIDTH, 16, opaque decoded control word passed through to EX

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode holds an instruction
id_ready  out  1  stage accepts the decode instruction this cycle
id_rs, id_rt, id_rd  in  ADDR_WIDTH each  source/destination indices (id_rs/id_rt also drive register-file rs/rt)
id_uses_rs, id_uses_rt, id_writes_rd, id_is_load  in  1 each  decode flags
id_ctrl  in  CTRL_WIDTH  control word
rf_data_rs, rf_data_rt  in  GPR_WIDTH each  register-file read data
mem_fwd_en  in  1  MEM-stage instruction writes a register
mem_fwd_rd  in  ADDR_WIDTH  its destination
mem_fwd_data  in  GPR_WIDTH  its result (load data included)
wb_en, wb_rd, wb_data  in  1/ADDR_WIDTH/GPR_WIDTH  same nets as register-file en/rd/data
flush  in  1  kill the EX-register contents
ex_ready  in  1  execute stage consumes the bundle
ex_valid  out  1  bundle valid
ex_rs_val, ex_rt_val  out  GPR_WIDTH each  resolved operands
ex_rs_alu_fwd, ex_rt_alu_fwd  out  1 each  operand must be taken from the ALU's previous result (EX->EX bypass)
ex_rd, ex_writes_rd, ex_is_load, ex_ctrl  out  pass-through of captured decode fields
stall_cnt  out  16  saturating count of load-use bubble cycles

Behaviour:
- **Reset:** asynchronous rst clears all registered outputs to 0 (ex_valid=0, ex_* data=0, flags=0, stall_cnt=0). id_ready is combinational and evaluates to 1 after reset.
- **Advance:**
  - adv = ex_ready | ~ex_valid.
  - hazard = ex_valid & ex_is_load & ex_writes_rd & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - id_ready = adv & ~hazard & ~flush.
- **Register update, evaluated in priority order at posedge:**
  1. flush=1: ex_valid<=0 regardless of adv; decode is not accepted.
  2. adv & id_valid & ~hazard: capture; ex_valid<=1.
  3. adv otherwise: bubble; ex_valid<=0, other fields don't-care but held.
  4. ~adv: all EX fields hold.
- **Operand resolution at capture, per source s (rs, rt), highest priority first:**
  1. ex_valid & ex_writes_rd & ~ex_is_load & id_s==ex_rd: set alu_fwd_s=1; value=rf data (unused by EX).
  2. mem_fwd_en & mem_fwd_rd==id_s: mem_fwd_data.
  3. wb_en & wb_rd==id_s: wb_data.
  4. Otherwise: rf_data_s.
- **Index rules:** no index is hardwired to zero, so r0 forwards like any register. Source flags (uses_s=0) suppress alu_fwd_s but value resolution still occurs.
- **Load-use:** a dependent instruction following a load waits exactly one bubble cycle. On the next cycle the load sits in MEM and its data arrives via mem_fwd.
- **Downstream contract:** EX must hold its previous ALU result stable while ex_ready=0, so held alu_fwd flags remain correct.
- **stall_cnt:** increments when id_valid & hazard & adv & ~flush, and saturates at 16'hFFFF.
- **Timing:** latency is 1 cycle from acceptance to ex_valid. Throughput is 1 per cycle absent hazards.
- **Reset mid-operation:** squashes the held bundle immediately; there is no pending state to recover.

Test Plan:
- Reset, then id_valid=1, rs=3, rt=4, rf 0x11/0x22, no fwd, ex_ready=1 -> next cycle ex_valid=1, ex_rs_val=0x11, ex_rt_val=0x22, flags 0.
- wb_en=1, wb_rd=3, wb_data=0xAA while capturing rs=3 (rf still old 0x11) -> ex_rs_val=0xAA. Add mem_fwd_rd=3 with data 0xBB simultaneously -> 0xBB (MEM beats WB).
- ADD r5 captured, then SUB rs=5 -> ex_rs_alu_fwd=1, ex_rt_alu_fwd=0. Repeat with uses_rs=0 -> flag 0.
- LW r6 captured, next id rt=6 -> id_ready=0, one bubble (ex_valid=0), stall_cnt=1. Following cycle mem_fwd r6=0x1234 -> accepted, ex_rt_val=0x1234.
- ex_ready=0 for 3 cycles with valid bundle -> outputs stable, id_ready=0. Assert flush -> ex_valid=0 next cycle even with ex_ready=0.
- rst asserted mid-stream between clock edges -> ex_valid and all outputs 0 immediately, without waiting for a clock edge.
